// File: rtl/memory_writeback_cycle_pkg.sv
// Shared constants, result-select encoding and the MEM/WB register layout
// for the memory/writeback pipeline slice.
package memory_writeback_cycle_pkg;

    localparam int unsigned DMEM_DEPTH_DEFAULT = 1024;
    localparam int unsigned WORD_LSB           = 2;

    typedef enum logic {
        RES_ALU = 1'b0,
        RES_MEM = 1'b1
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } memwb_t;

    // Loads and stores must be word aligned; plain ALU ops never fault.
    function automatic logic is_misaligned(
        input logic       mem_write,
        input logic       result_src,
        input logic [1:0] offset
    );
        return (mem_write || result_src) && (offset != 2'b00);
    endfunction

endpackage

// File: rtl/memory_writeback_cycle_data_memory.sv
// Word-addressed data memory: asynchronous read, synchronous write.
// Contents survive reset; upper address bits alias so addresses wrap.
module Data_memory
    import memory_writeback_cycle_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH] = '{default: '0};
    logic [AW-1:0] word_idx;
    logic          write_en;
    logic          unused_addr_bits;

    assign word_idx         = A[AW+WORD_LSB-1:WORD_LSB];
    assign unused_addr_bits = ^A[31:AW+WORD_LSB];

    // Writes are refused during reset and for any unaligned byte address.
    assign write_en = WE && rst && (A[WORD_LSB-1:0] == '0);

    assign RD = mem[word_idx];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[word_idx] <= WD;
        end
    end

endmodule

// File: rtl/memory_writeback_cycle.sv
// Memory and writeback stages: data memory access, MEM/WB register,
// writeback result mux and a sticky misaligned-access flag.
module memory_writeback_cycle
    import memory_writeback_cycle_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW,
    output logic        MisalignedW
);

    logic        misaligned;
    logic        store_en;
    logic [31:0] read_data;
    memwb_t      memwb_d;
    memwb_t      memwb_q;
    logic        misaligned_q;

    assign misaligned = is_misaligned(MemWriteM, ResultSrcM, ALUResultM[1:0]);
    assign store_en   = MemWriteM && !misaligned;

    Data_memory #(
        .DEPTH(DMEM_DEPTH)
    ) u_dmem (
        .clk(clk),
        .rst(rst),
        .WE (store_en),
        .A  (ALUResultM),
        .WD (WriteDataM),
        .RD (read_data)
    );

    // A faulting load must not commit to the register file.
    always_comb begin
        memwb_d            = '0;
        memwb_d.reg_write  = RegWriteM && !(ResultSrcM && misaligned);
        memwb_d.result_src = result_src_t'(ResultSrcM);
        memwb_d.rd         = RdM;
        memwb_d.alu_result = ALUResultM;
        memwb_d.read_data  = read_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            memwb_q <= memwb_d;
            if (misaligned) begin
                misaligned_q <= 1'b1;
            end
        end
    end

    assign RegWriteW   = memwb_q.reg_write;
    assign RDW         = memwb_q.rd;
    assign ResultW     = (memwb_q.result_src == RES_MEM) ? memwb_q.read_data
                                                         : memwb_q.alu_result;
    assign MisalignedW = misaligned_q;

endmodule

// File: doc/memory_writeback_cycle.md
MEMORY_WRITEBACK_CYCLE -- requirements
Module: memory_writeback_cycle

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- RegWriteM  input  1  memory-stage register-write enable.
- ResultSrcM  input  1  result select: 1 = load data, 0 = ALU result.
- MemWriteM  input  1  store enable.
- RdM  input  5  destination register.
- ALUResultM  input  32  ALU result, used as the byte address for loads and stores.
- WriteDataM  input  32  store data.
- RegWriteW  output  1  register-file write enable, drives decode WE3.
- RDW  output  5  register-file write address, drives decode A3.
- ResultW  output  32  register-file write data, drives decode WD3.
- MisalignedW  output  1  sticky error flag for a misaligned access.
REQ-002 The block SHALL have this parameter:
- DMEM_DEPTH, default 1024, data memory depth in 32-bit words (power of two).

Function
REQ-003 The data memory SHALL be word-addressed, indexed by ALUResultM[log2(DMEM_DEPTH)+1:2].
REQ-004 Higher address bits SHALL be ignored, so addresses wrap modulo DMEM_DEPTH*4 bytes.
REQ-005 A store SHALL write WriteDataM on the rising clk edge when all of these hold: MemWriteM=1, ALUResultM[1:0]=00, rst=1.
REQ-006 A load read SHALL be combinational from the current address (asynchronous read).
REQ-007 A store in cycle n SHALL be visible to a load of the same word in cycle n+1.
REQ-008 The MEM/WB register SHALL capture on every rising edge: RegWrite, ResultSrc, Rd, ALUResult, and load data.
REQ-009 Latency: M-stage inputs present before edge n SHALL appear on the W outputs after edge n (one cycle).
REQ-010 No stall or flush input exists; the register SHALL advance every cycle.
REQ-011 ResultW SHALL be combinational from the MEM/WB register: ResultW = ResultSrcW ? ReadDataW : ALUResultW.
REQ-012 RDW SHALL equal the registered RdM.
REQ-013 RegWriteW SHALL equal the registered RegWriteM, except that a misaligned load forces the registered RegWrite to 0.
REQ-014 A misaligned access is (MemWriteM=1 or ResultSrcM=1) with ALUResultM[1:0]≠00.
REQ-015 A misaligned store SHALL be suppressed; memory SHALL be unchanged.
REQ-016 MisalignedW SHALL set on the edge after a misaligned access and SHALL hold 1 until reset.
REQ-017 If RdM=0 with RegWriteM=1, RDW SHALL be 0 and RegWriteW SHALL be 1; x0 protection belongs to the register file.

Reset
REQ-018 While rst=0, these outputs SHALL be 0 immediately (asynchronously): RegWriteW, RDW, ResultW, MisalignedW, and all MEM/WB register fields.
REQ-019 Data memory contents SHALL NOT be cleared by reset; simulation SHALL initialise them to 0.
REQ-020 A store presented on an edge where rst=0 SHALL NOT write memory.
REQ-021 After rst deasserts, the first edge SHALL capture inputs normally.

Structure
REQ-022 A shared constants package/include SHALL hold: DMEM_DEPTH default, word-offset LSB (2), and ResultSrc encodings (ALU=0, MEM=1).
REQ-023 The data memory SHALL be one sub-module, Data_memory.
- Ports: clk, rst, WE, A[31:0], WD[31:0], RD[31:0].
- Behaviour: asynchronous read, synchronous write.
REQ-024 The MEM/WB register, writeback mux and error flag SHALL reside in memory_writeback_cycle.

Verification
REQ-025 Reset: hold rst=0 with random M inputs -> RegWriteW, RDW, ResultW and MisalignedW are all 0, asynchronously.
REQ-026 Store then load:
- cycle 0: MemWriteM=1, ALUResultM=0x8, WriteDataM=0x0000000B.
- cycle 1: ResultSrcM=1, RegWriteM=1, RdM=5, ALUResultM=0x8.
- response after cycle-1 edge: RegWriteW=1, RDW=5, ResultW=0x0000000B.
REQ-027 ALU passthrough: ResultSrcM=0, RegWriteM=1, RdM=3, ALUResultM=0x00000007 -> next cycle ResultW=0x7, RDW=3, RegWriteW=1.
REQ-028 Wrap-around (DMEM_DEPTH=1024): store 0xDEADBEEF at 0x1004, then load 0x0004 -> ResultW=0xDEADBEEF.
REQ-029 Misaligned accesses:
- store 0x12345678 at 0x6 -> following load at 0x4 returns the prior contents; MisalignedW=1 and stays 1.
- load at 0x5 with RegWriteM=1 -> RegWriteW=0.
REQ-030 Reset mid-operation: drive rst=0 across an edge with MemWriteM=1, ALUResultM=0x10, WriteDataM=0xFF -> memory word 4 is unchanged and the outputs are cleared.
